// File: rtl/axi4_burst_reg_slave.sv
// AXI4 burst slave that terminates read/write bursts into a DEPTH x DATA_WIDTH register array.
// Ports: ACLK/ARESET, SLAVE_AW*/W*/B* write channels, SLAVE_AR*/R* read channels.
module axi4_burst_reg_slave #(
    parameter int ID_WIDTH   = 1,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int DEPTH      = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ID_WIDTH-1:0]     SLAVE_AWID,
    input  logic [ADDR_WIDTH-1:0]   SLAVE_AWADDR,
    input  logic [7:0]              SLAVE_AWLEN,
    input  logic [2:0]              SLAVE_AWSIZE,
    input  logic [1:0]              SLAVE_AWBURST,
    input  logic                    SLAVE_AWVALID,
    output logic                    SLAVE_AWREADY,
    input  logic [DATA_WIDTH-1:0]   SLAVE_WDATA,
    input  logic [DATA_WIDTH/8-1:0] SLAVE_WSTRB,
    input  logic                    SLAVE_WLAST,
    input  logic                    SLAVE_WVALID,
    output logic                    SLAVE_WREADY,
    output logic [ID_WIDTH-1:0]     SLAVE_BID,
    output logic [1:0]              SLAVE_BRESP,
    output logic [USER_WIDTH-1:0]   SLAVE_BUSER,
    output logic                    SLAVE_BVALID,
    input  logic                    SLAVE_BREADY,
    input  logic [ID_WIDTH-1:0]     SLAVE_ARID,
    input  logic [ADDR_WIDTH-1:0]   SLAVE_ARADDR,
    input  logic [7:0]              SLAVE_ARLEN,
    input  logic [2:0]              SLAVE_ARSIZE,
    input  logic [1:0]              SLAVE_ARBURST,
    input  logic                    SLAVE_ARVALID,
    output logic                    SLAVE_ARREADY,
    output logic [ID_WIDTH-1:0]     SLAVE_RID,
    output logic [DATA_WIDTH-1:0]   SLAVE_RDATA,
    output logic [1:0]              SLAVE_RRESP,
    output logic                    SLAVE_RLAST,
    output logic [USER_WIDTH-1:0]   SLAVE_RUSER,
    output logic                    SLAVE_RVALID,
    input  logic                    SLAVE_RREADY
);

    localparam int LSB = $clog2(DATA_WIDTH / 8);
    localparam int IW  = $clog2(DEPTH);
    localparam int WW  = ADDR_WIDTH - LSB;
    localparam int SW  = DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // WRAP, reserved burst type and narrow/wide beats are all rejected
    function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size);
        return burst[1] || (size != 3'(LSB));
    endfunction

    // Range check uses the full word address so INCR past the top goes DECERR
    function automatic logic in_range(input logic [WW-1:0] word);
        return (word >> IW) == '0;
    endfunction

    // Byte offset bits never affect decode
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{SLAVE_AWADDR[LSB-1:0], SLAVE_ARADDR[LSB-1:0]};

    // ---------------- write channel ----------------
    w_state_t             w_state, w_next;
    logic [ID_WIDTH-1:0]  w_id;
    logic [WW-1:0]        w_word;
    logic [7:0]           w_len, w_beat;
    logic                 w_fixed, w_err, w_slverr, w_decerr;
    logic                 aw_hs, w_hs;

    always_ff @(posedge ACLK) begin
        if (ARESET) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    always_comb begin
        w_next        = w_state;
        SLAVE_AWREADY = 1'b0;
        SLAVE_WREADY  = 1'b0;
        SLAVE_BVALID  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                SLAVE_AWREADY = 1'b1;
                if (SLAVE_AWVALID) w_next = W_DATA;
            end
            W_DATA: begin
                SLAVE_WREADY = 1'b1;
                if (SLAVE_WVALID && (w_beat == w_len)) w_next = W_RESP;
            end
            W_RESP: begin
                SLAVE_BVALID = 1'b1;
                if (SLAVE_BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign aw_hs       = SLAVE_AWVALID && SLAVE_AWREADY;
    assign w_hs        = SLAVE_WVALID && SLAVE_WREADY;
    assign SLAVE_BID   = w_id;
    assign SLAVE_BRESP = w_slverr ? 2'b10 : (w_decerr ? 2'b11 : 2'b00);
    assign SLAVE_BUSER = '0;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_id     <= '0;
            w_word   <= '0;
            w_len    <= '0;
            w_beat   <= '0;
            w_fixed  <= 1'b0;
            w_err    <= 1'b0;
            w_slverr <= 1'b0;
            w_decerr <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (aw_hs) begin
                w_id     <= SLAVE_AWID;
                w_word   <= SLAVE_AWADDR[ADDR_WIDTH-1:LSB];
                w_len    <= SLAVE_AWLEN;
                w_beat   <= '0;
                w_fixed  <= (SLAVE_AWBURST == 2'b00);
                w_err    <= burst_err(SLAVE_AWBURST, SLAVE_AWSIZE);
                w_slverr <= burst_err(SLAVE_AWBURST, SLAVE_AWSIZE);
                w_decerr <= 1'b0;
            end
            if (w_hs) begin
                if (!w_err && in_range(w_word)) begin
                    for (int b = 0; b < SW; b++) begin
                        if (SLAVE_WSTRB[b])
                            mem[w_word[IW-1:0]][b*8 +: 8] <= SLAVE_WDATA[b*8 +: 8];
                    end
                end
                if (!in_range(w_word)) w_decerr <= 1'b1;
                // Beat count ends the burst; a misplaced WLAST only taints the response
                if (SLAVE_WLAST != (w_beat == w_len)) w_slverr <= 1'b1;
                w_beat <= w_beat + 8'd1;
                if (!w_fixed) w_word <= w_word + 1'b1;
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_t               r_state, r_next;
    logic [ID_WIDTH-1:0]    r_id;
    logic [WW-1:0]          r_word, sel_word;
    logic [7:0]             r_len, r_beat;
    logic                   r_fixed, r_err, sel_err;
    logic [DATA_WIDTH-1:0]  r_data, sel_data;
    logic [1:0]             r_resp, sel_resp;
    logic                   r_last, ar_hs, r_hs;

    always_ff @(posedge ACLK) begin
        if (ARESET) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    always_comb begin
        r_next        = r_state;
        SLAVE_ARREADY = 1'b0;
        SLAVE_RVALID  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                SLAVE_ARREADY = 1'b1;
                if (SLAVE_ARVALID) r_next = R_DATA;
            end
            R_DATA: begin
                SLAVE_RVALID = 1'b1;
                if (SLAVE_RREADY && r_last) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign ar_hs = SLAVE_ARVALID && SLAVE_ARREADY;
    assign r_hs  = SLAVE_RVALID && SLAVE_RREADY;

    // Beat to present next: beat 0 of a new burst, or the successor beat.
    // The array is sampled before this edge's write lands, so a same-edge
    // write only shows up on later beats.
    always_comb begin
        sel_word = r_fixed ? r_word : r_word + 1'b1;
        sel_err  = r_err;
        if (ar_hs) begin
            sel_word = SLAVE_ARADDR[ADDR_WIDTH-1:LSB];
            sel_err  = burst_err(SLAVE_ARBURST, SLAVE_ARSIZE);
        end
        sel_data = '0;
        sel_resp = 2'b00;
        if (sel_err)                 sel_resp = 2'b10;
        else if (!in_range(sel_word)) sel_resp = 2'b11;
        else                          sel_data = mem[sel_word[IW-1:0]];
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_id    <= '0;
            r_word  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_fixed <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= '0;
            r_resp  <= 2'b00;
            r_last  <= 1'b0;
        end else if (ar_hs) begin
            r_id    <= SLAVE_ARID;
            r_len   <= SLAVE_ARLEN;
            r_beat  <= '0;
            r_fixed <= (SLAVE_ARBURST == 2'b00);
            r_err   <= sel_err;
            r_word  <= sel_word;
            r_data  <= sel_data;
            r_resp  <= sel_resp;
            r_last  <= (SLAVE_ARLEN == 8'd0);
        end else if (r_hs) begin
            if (r_last) begin
                r_last <= 1'b0;
            end else begin
                r_beat <= r_beat + 8'd1;
                r_word <= sel_word;
                r_data <= sel_data;
                r_resp <= sel_resp;
                r_last <= ((r_beat + 8'd1) == r_len);
            end
        end
    end

    assign SLAVE_RID   = r_id;
    assign SLAVE_RDATA = r_data;
    assign SLAVE_RRESP = r_resp;
    assign SLAVE_RLAST = r_last;
    assign SLAVE_RUSER = '0;

endmodule

// File: doc/axi4_burst_reg_slave.md
Name: axi4_burst_reg_slave

Overview:
AXI4 slave endpoint that sits directly downstream of the AXI-to-AXI connect stage and consumes its MASTER_* outputs. It terminates AXI4 read and write bursts into a DEPTH-entry register array of DATA_WIDTH words. It provides the target for bring-up traffic and crypto-engine control/status registers. The write and read channels run independent FSMs that share the array.

Parameters:
ID_WIDTH, 1, width of AWID/BID/ARID/RID
DATA_WIDTH, 64, data width; 32 or 64 only
ADDR_WIDTH, 32, address width
USER_WIDTH, 1, width of BUSER/RUSER
DEPTH, 16, register count; power of 2, 2..256

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  synchronous active-high reset
SLAVE_AWID  in  ID_WIDTH  write ID
SLAVE_AWADDR  in  ADDR_WIDTH  write start address
SLAVE_AWLEN  in  8  beats-1
SLAVE_AWSIZE  in  3  bytes/beat log2
SLAVE_AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP
SLAVE_AWVALID  in  1  AW valid
SLAVE_AWREADY  out  1  AW ready
SLAVE_WDATA  in  DATA_WIDTH  write data
SLAVE_WSTRB  in  DATA_WIDTH/8  byte strobes
SLAVE_WLAST  in  1  last write beat
SLAVE_WVALID  in  1  W valid
SLAVE_WREADY  out  1  W ready
SLAVE_BID  out  ID_WIDTH  response ID
SLAVE_BRESP  out  2  write response
SLAVE_BUSER  out  USER_WIDTH  tied 0
SLAVE_BVALID  out  1  B valid
SLAVE_BREADY  in  1  B ready
SLAVE_ARID  in  ID_WIDTH  read ID
SLAVE_ARADDR  in  ADDR_WIDTH  read start address
SLAVE_ARLEN  in  8  beats-1
SLAVE_ARSIZE  in  3  bytes/beat log2
SLAVE_ARBURST  in  2  burst type
SLAVE_ARVALID  in  1  AR valid
SLAVE_ARREADY  out  1  AR ready
SLAVE_RID  out  ID_WIDTH  read ID
SLAVE_RDATA  out  DATA_WIDTH  read data
SLAVE_RRESP  out  2  read response
SLAVE_RLAST  out  1  last read beat
SLAVE_RUSER  out  USER_WIDTH  tied 0
SLAVE_RVALID  out  1  R valid
SLAVE_RREADY  in  1  R ready

Behaviour:
- Reset, synchronous: all registers become 0; both FSMs go to IDLE. Next cycle: AWREADY=1, ARREADY=1, WREADY=0, BVALID=0, RVALID=0, RLAST=0, BRESP/RRESP=00, RDATA=0, BID/RID=0.
- Reset mid-burst: the burst is abandoned with no response, and the same values as above apply.
- Address decode:
  - LSB = log2(DATA_WIDTH/8); IW = log2(DEPTH); index = ADDR[LSB+IW-1:LSB].
  - An address is in range when ADDR[ADDR_WIDTH-1:LSB+IW]==0.
- Burst error: a burst is flagged err when AxBURST==WRAP, AxBURST==11, or AxSIZE != LSB.
- Beat addressing: INCR adds 1 to the index per beat, and the index wraps mod DEPTH. The range check is evaluated per beat on the full incremented word address. FIXED keeps the same index on every beat.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: AWREADY=1. The AW handshake latches ID, address, len, burst and err, then moves to W_DATA. WREADY=1 from the next cycle.
  - W_DATA: each W handshake writes strobed bytes when the beat is in range and err=0; otherwise the write is dropped. The beat counter reaches AWLEN, then the FSM moves to W_RESP and BVALID=1 on the next cycle.
  - Beat count, not WLAST, ends the burst. WLAST != (beat==AWLEN) on any beat sets a sticky SLVERR.
  - BRESP priority: err or WLAST mismatch -> SLVERR(10); else any out-of-range beat -> DECERR(11); else OKAY(00).
  - W_RESP: BVALID, BID and BRESP are held stable until BREADY. Then W_IDLE with AWREADY=1 on the next cycle.
- Read FSM, R_IDLE -> R_DATA:
  - R_IDLE: ARREADY=1. The AR handshake latches fields; RVALID=1 with beat 0 on the next cycle (1-cycle latency).
  - R_DATA: RDATA, RRESP, RLAST and RID are held stable while RVALID && !RREADY. On handshake the next beat is presented in the following cycle, so there are no bubbles while RREADY=1.
  - RLAST=1 only on beat ARLEN. After the last handshake: R_IDLE, RVALID=0, ARREADY=1.
  - Per-beat RRESP: err -> SLVERR with RDATA=0; out-of-range -> DECERR with RDATA=0; else OKAY with array data.
- Simultaneous access to one index: a read beat presented in cycle N reflects writes committed before edge N. A same-edge write becomes visible on later beats.
- Channel independence: write and read proceed concurrently. Each FSM holds at most one outstanding burst; there is no interleaving.
- Unused inputs: AWID/ARID widths pass through unmodified. Lock, cache, prot, qos, region and user inputs from the upstream stage are not ports and are left unconnected.

Test Plan:
1. INCR write, AWADDR=0x10, AWLEN=3, WSTRB=0xFF, data A0..A3 -> regs[2..5]=A0..A3, then BVALID one cycle after the 4th W handshake with BRESP=00 and BID=AWID. INCR read of the same range returns A0..A3 with RLAST on beat 3.
2. Backpressure: read ARLEN=7 with RREADY toggling 1,0,0,1 -> RDATA/RLAST stable while stalled, 8 beats in order, no duplicates. BREADY held 0 for 5 cycles -> BVALID and BRESP stable, AWREADY=0 throughout.
3. Errors:
   - AWBURST=WRAP -> no register changes, BRESP=10.
   - ARADDR=0x80 (DEPTH=16, 64-bit) -> RRESP=11, RDATA=0.
   - INCR read at 0x78 with ARLEN=1 -> beat 0 OKAY, beat 1 DECERR.
4. Strobes: write 0xFFFF... then WSTRB=0x0F with data 0 -> reg = 0xFFFFFFFF00000000. FIXED write, AWLEN=2, data 1,2,3 -> reg holds 3.
5. WLAST asserted on beat 1 of AWLEN=3 -> 4 beats still accepted, BRESP=10. ARESET pulsed mid read burst -> RVALID=0 next cycle, all regs 0, new AR accepted.
